dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory target that serves load/store requests from the core's memory port over a valid/ready request channel and a valid/ready response channel.
- Decodes the RISC-V access size and signedness from funct3 and drives per-byte lane enables.
- Performs sign or zero extension of load data inside the block, so the datapath receives final register write-back values.
- Fixed, parameterisable access latency; one outstanding request.

Parameters:
- DATA_W, 32, data width; only 32 is supported.
- DM_ADDRESS, 9, byte-address width; storage is 2^(DM_ADDRESS-2) words.
- MEM_LAT, 2, cycles from request acceptance to rsp_valid; minimum 1.

Ports:
- clk  in  1  global clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  DM_ADDRESS  byte address
- req_wdata  in  DATA_W  store data; low bytes are used for SB/SH
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors
- rsp_err  out  1  illegal funct3 or misaligned access

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- Reset values:
  - FSM goes to IDLE.
  - req_ready=1 in the first cycle after reset is released; it is 0 while reset is asserted.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Latency counter = 0.
  - Storage array is not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata. Go to WAIT with cnt=MEM_LAT-1, or go directly to RESP if MEM_LAT==1.
  - WAIT: req_ready=0. Decrement cnt each cycle. When cnt==1, go to RESP on the next edge.
  - RESP: rsp_valid=1 and rsp_rdata/rsp_err held stable until rsp_ready. On rsp_valid & rsp_ready, go to IDLE.
  - No new request is accepted in the same cycle as the response handshake. Throughput is 1 access per MEM_LAT+1 cycles when rsp_ready is held high.
- Latency: accept at edge T gives rsp_valid high in cycle T+MEM_LAT.
- Commit point: the memory read/write and the registering of rsp_rdata/rsp_err happen on the edge that enters RESP. Backpressure on rsp_ready never causes a repeated write.
- Lane decode, with word index = addr[DM_ADDRESS-1:2]:
  - B/BU: lane addr[1:0].
  - H/HU: lanes {addr[1],0} and {addr[1],1}.
  - W: all four lanes.
- Stores:
  - SB writes wdata[7:0] into the selected lane.
  - SH writes wdata[15:0] into the selected lanes.
  - SW writes the full word.
  - Unselected lanes are unchanged. rsp_rdata=0.
- Loads:
  - LB/LH: sign-extend bit 7 / bit 15 of the selected bytes.
  - LBU/LHU: zero-extend.
  - LW: full word.
- Illegal funct3 (011, 110, 111): rsp_err=1, rsp_rdata=0, no write, same latency.
- Misaligned access (H with addr[0]=1, W with addr[1:0]!=0): handled as described under Optional Feature.
- Reset mid-operation: the latched request is dropped. A store not yet committed is not performed, and rsp_valid is 0 from the next cycle.
- Requests with req_valid=0 are ignored in all states. Inputs are only sampled in IDLE.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined: a misaligned access gives rsp_err=1 and rsp_rdata=0, and no store is performed.
- Undefined: the address is forced to natural alignment (addr[0] cleared for H, addr[1:0] cleared for W). The access completes normally and rsp_err is always 0 for misalignment. Illegal funct3 still sets rsp_err.

Test Plan:
- MEM_LAT=2. SW addr 0x010 wdata 0x8765_4321, then LW 0x010. Required: rsp_valid exactly 2 cycles after each accept; LW rsp_rdata=0x8765_4321; rsp_err=0.
- After the above, SB addr 0x013 wdata 0x0000_00A5, then LB 0x013 and LBU 0x013. Required: LB returns 0xFFFF_FFA5, LBU returns 0x0000_00A5, and LW 0x010 returns 0xA565_4321.
- SH addr 0x022 wdata 0x0000_F00D, then LH 0x022 and LHU 0x022. Required: LH returns 0xFFFF_F00D, LHU returns 0x0000_F00D, and the word at 0x020 lower half is unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles during an SW. Required: rsp_valid and rsp_err stay stable, req_ready=0 throughout, and the store is performed exactly once (a subsequent LW returns the stored data).
- LW addr 0x011 with the macro defined. Required: rsp_err=1, rsp_rdata=0. With the macro undefined, LW 0x011 returns the word at 0x010 and rsp_err=0. funct3=011 gives rsp_err=1 in both builds.
- Assert reset for one cycle while in WAIT for an SW 0x030 0xDEAD_BEEF. Required: rsp_valid=0, req_ready=1 one cycle after reset deasserts, and a later LW 0x030 does not return 0xDEAD_BEEF.

Source files
------------

// File: rtl/dmem_if.sv
// dmem_if: core <-> data-memory request/response channel.
//   req_*  : valid/ready request (we, funct3, byte address, store data)
//   rsp_*  : valid/ready response (extended load data, error flag)
// master = core side, slave = memory responder side.
interface dmem_if #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory target for RISC-V loads/stores.
//   clk    : clock
//   reset  : synchronous active-high reset
//   bus    : dmem_if.slave (request and response valid/ready channels)
// Parameters: DATA_W (32 only), DM_ADDRESS (byte-address width),
//   MEM_LAT (cycles from request cycle to rsp_valid, >= 1).
// Storage is split into per-byte lanes (dmem_lane), one instance per lane.
// Build option: define DMEM_MISALIGN_CHECK_EN to flag misaligned H/W
// accesses as errors; otherwise the address is forced to natural alignment.

module dmem_lane #(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    wbyte,
  output logic [7:0]    rbyte
);
  logic [7:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wbyte;

  // asynchronous read: the read value is sampled into rsp_rdata on the
  // same edge that may write this lane, so loads see pre-write contents
  assign rbyte = mem[idx];
endmodule

module dmem_responder #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int MEM_LAT    = 2
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam int WAW       = DM_ADDRESS - 2;
  localparam int CW        = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic                  we;
    logic [2:0]            funct3;
    logic [DM_ADDRESS-1:0] addr;
    logic [DATA_W-1:0]     wdata;
  } req_t;

  state_t                       state, state_nxt;
  logic [CW-1:0]                cnt;
  req_t                         req_in, req_q, acc;
  logic                         accept, commit;
  logic                         is_byte, is_half, is_word, illegal, misal, err;
  logic [1:0]                   boff;
  logic [WAW-1:0]               widx;
  logic [NUM_LANES-1:0]         lane_en, lane_we;
  logic [NUM_LANES-1:0][7:0]    lane_wd, lane_rd;
  logic [DATA_W-1:0]            rword, ld_data;
  logic [7:0]                   bsel;
  logic [15:0]                  hsel;

  assign req_in = '{we: bus.req_we, funct3: bus.req_funct3,
                    addr: bus.req_addr, wdata: bus.req_wdata};

  assign accept = (state == IDLE) && bus.req_valid && !reset;

  // commit on the edge that enters RESP; with MEM_LAT==1 that is the
  // accept edge itself, so the live inputs are used instead of req_q
  assign commit = !reset && (((state == WAIT) && (cnt == CW'(1))) ||
                             (accept && (MEM_LAT == 1)));
  assign acc    = (state == IDLE) ? req_in : req_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)             cnt <= CW'(MEM_LAT - 1);
      else if (state == WAIT) cnt <= cnt - CW'(1);
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.req_valid) state_nxt = (MEM_LAT == 1) ? RESP : WAIT;
      WAIT: if (cnt == CW'(1)) state_nxt = RESP;
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE:    bus.req_ready = !reset;
      RESP:    bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // request latch; inputs are only looked at in IDLE
  always_ff @(posedge clk)
    if (accept) req_q <= req_in;

  // ---------------- decode ----------------
  always_comb begin
    is_byte = (acc.funct3[1:0] == 2'b00);
    is_half = (acc.funct3[1:0] == 2'b01);
    is_word = (acc.funct3 == 3'b010);
    illegal = !(is_byte || is_half || is_word);
    misal   = (is_half && acc.addr[0]) || (is_word && (acc.addr[1:0] != 2'b00));
`ifdef DMEM_MISALIGN_CHECK_EN
    err  = illegal || misal;
    boff = acc.addr[1:0];
`else
    err  = illegal;
    boff = is_word ? 2'b00 : is_half ? {acc.addr[1], 1'b0} : acc.addr[1:0];
`endif
  end

  assign widx = acc.addr[DM_ADDRESS-1:2];

  // ---------------- byte lanes ----------------
  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      assign lane_en[i] = is_word ||
                          (is_half && (boff[1] == 1'(i >> 1))) ||
                          (is_byte && (boff == 2'(i)));
      assign lane_we[i] = commit && acc.we && !err && lane_en[i];
      // SB replicates the low byte, SH the low half, SW maps straight across
      assign lane_wd[i] = is_word ? acc.wdata[8*i +: 8] :
                          is_half ? acc.wdata[8*(i%2) +: 8] :
                                    acc.wdata[7:0];

      dmem_lane #(.AW(WAW)) u_lane (
        .clk   (clk),
        .we    (lane_we[i]),
        .idx   (widx),
        .wbyte (lane_wd[i]),
        .rbyte (lane_rd[i])
      );
    end
  endgenerate

  assign rword = lane_rd;

  // ---------------- load extraction / extension ----------------
  always_comb begin
    bsel    = rword[{boff, 3'b000} +: 8];
    hsel    = rword[{boff[1], 4'b0000} +: 16];
    ld_data = '0;
    if (!acc.we && !err) begin
      if (is_byte)
        ld_data = {{(DATA_W-8){!acc.funct3[2] && bsel[7]}}, bsel};
      else if (is_half)
        ld_data = {{(DATA_W-16){!acc.funct3[2] && hsel[15]}}, hsel};
      else
        ld_data = rword;
    end
  end

  // response registers load once at commit and hold through backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else if (commit) begin
      bus.rsp_rdata <= ld_data;
      bus.rsp_err   <= err;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_if #(.DATA_W(32), .DM_ADDRESS(9)) bus ();

  dmem_responder #(.DATA_W(32), .DM_ADDRESS(9), .MEM_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int nchk = 0;
  int nfail = 0;
  logic [7:0] mm [512];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: byte-addressed array, size/sign from funct3
  task automatic model_access(input logic we, input logic [2:0] f3, input int a,
                              input logic [31:0] wd, output logic [31:0] rd,
                              output logic er);
    int sz, base;
    bit uns;
    logic [31:0] v;
    rd = '0; er = 1'b0; uns = f3[2];
    case (f3)
      3'b000, 3'b100: sz = 1;
      3'b001, 3'b101: sz = 2;
      3'b010:         sz = 4;
      default:        sz = 0;
    endcase
    if (sz == 0) begin er = 1'b1; return; end
    base = a;
    if (a % sz != 0) begin
`ifdef DMEM_MISALIGN_CHECK_EN
      er = 1'b1; return;
`else
      base = a - (a % sz);
`endif
    end
    if (we) begin
      for (int k = 0; k < sz; k++) mm[base+k] = wd[8*k +: 8];
      return;
    end
    v = '0;
    for (int k = 0; k < sz; k++) v = v | (32'(mm[base+k]) << (8*k));
    if (!uns && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
    rd = v;
  endtask

  task automatic access(input logic we, input logic [2:0] f3, input logic [8:0] a,
                        input logic [31:0] wd, input int bp,
                        output logic [31:0] rd, output logic er);
    logic [31:0] erd;
    logic eer;
    int lat;
    logic bad;
    model_access(we, f3, int'(a), wd, erd, eer);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd; bus.rsp_ready = (bp == 0);
    bad = ~bus.req_ready;
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (lat == 1) bus.req_valid = 1'b0;
      bad |= bus.req_ready;
    end while (!bus.rsp_valid && lat < 20);
    chk("latency", 32'(lat), 32'(LAT));
    rd = bus.rsp_rdata; er = bus.rsp_err;
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); @(negedge clk);
      bad |= !bus.rsp_valid || (bus.rsp_rdata !== rd) || (bus.rsp_err !== er) || bus.req_ready;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("handshake_done", {31'b0, bus.rsp_valid}, 32'd0);
    chk("stable_ready", {31'b0, bad}, 32'd0);
    chk("rdata", rd, erd);
    chk("err", {31'b0, er}, {31'b0, eer});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, lo20;
    logic er;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_err",   {31'b0, bus.rsp_err}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, bus.req_ready}, 32'd1);

    // give every word a known value
    for (int w = 0; w < 128; w++) access(1'b1, 3'b010, 9'(w*4), $urandom, 0, rd, er);

    access(1'b1, 3'b010, 9'h010, 32'h8765_4321, 0, rd, er);
    access(1'b0, 3'b010, 9'h010, 32'h0, 0, rd, er);
    chk("lw_010", rd, 32'h8765_4321);

    access(1'b1, 3'b000, 9'h013, 32'h0000_00A5, 0, rd, er);
    access(1'b0, 3'b000, 9'h013, 32'h0, 0, rd, er);
    chk("lb_013", rd, 32'hFFFF_FFA5);
    access(1'b0, 3'b100, 9'h013, 32'h0, 0, rd, er);
    chk("lbu_013", rd, 32'h0000_00A5);
    access(1'b0, 3'b010, 9'h010, 32'h0, 0, rd, er);
    chk("lw_010_sb", rd, 32'hA565_4321);

    access(1'b0, 3'b010, 9'h020, 32'h0, 0, lo20, er);
    access(1'b1, 3'b001, 9'h022, 32'h0000_F00D, 0, rd, er);
    access(1'b0, 3'b001, 9'h022, 32'h0, 0, rd, er);
    chk("lh_022", rd, 32'hFFFF_F00D);
    access(1'b0, 3'b101, 9'h022, 32'h0, 0, rd, er);
    chk("lhu_022", rd, 32'h0000_F00D);
    access(1'b0, 3'b010, 9'h020, 32'h0, 0, rd, er);
    chk("lw_020_lo", {16'h0, rd[15:0]}, {16'h0, lo20[15:0]});

    // backpressure on a store
    access(1'b1, 3'b010, 9'h040, 32'h1357_9BDF, 5, rd, er);
    access(1'b0, 3'b010, 9'h040, 32'h0, 0, rd, er);
    chk("bp_lw_040", rd, 32'h1357_9BDF);

    // misaligned word load, illegal funct3
    access(1'b0, 3'b010, 9'h011, 32'h0, 0, rd, er);
`ifdef DMEM_MISALIGN_CHECK_EN
    chk("mis_lw_err", {31'b0, er}, 32'd1);
    chk("mis_lw_rd", rd, 32'h0);
`else
    chk("mis_lw_err", {31'b0, er}, 32'd0);
    chk("mis_lw_rd", rd, 32'hA565_4321);
`endif
    access(1'b1, 3'b011, 9'h050, 32'hFFFF_FFFF, 0, rd, er);
    chk("ill_err", {31'b0, er}, 32'd1);
    access(1'b0, 3'b011, 9'h010, 32'h0, 0, rd, er);
    chk("ill_ld_rd", rd, 32'h0);

    // reset while a store waits; it must not commit
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 9'h030; bus.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("midrst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    access(1'b0, 3'b010, 9'h030, 32'h0, 0, rd, er);
    chk("midrst_nostore", {31'b0, rd == 32'hDEAD_BEEF}, 32'd0);

    // randomized traffic against the model
    for (int n = 0; n < 300; n++)
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             9'($urandom_range(0, 511)), $urandom, $urandom_range(0, 3), rd, er);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end
endmodule
